// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core.
// Opcodes, functs, FSM states and ALU operations.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_SLT, ALU_SLL, ALU_SRL, ALU_NOP
  } alu_op_t;

endpackage

// File: rtl/m_regfile_rn.sv
// 32x32 register file, two async reads, one sync write.
// Register 0 reads as zero and ignores writes.
module m_regfile_rn (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic [4:0]  w_ra1,
  input  logic [4:0]  w_ra2,
  input  logic        w_we,
  input  logic [4:0]  w_wa,
  input  logic [31:0] w_wd,
  output logic [31:0] w_rd1,
  output logic [31:0] w_rd2
);

  logic [31:0] r_mem [32];

  // write port; r0 never takes a write
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (w_we && (w_wa != 5'd0)) begin
      r_mem[w_wa] <= w_wd;
    end
  end

  // read ports with r0 forced to zero
  always_comb begin
    w_rd1 = (w_ra1 == 5'd0) ? 32'd0 : r_mem[w_ra1];
    w_rd2 = (w_ra2 == 5'd0) ? 32'd0 : r_mem[w_ra2];
  end

endmodule

// File: rtl/m_proc_mc.sv
// Multi-cycle MIPS-subset core: IF/ID/EX/MEM/WB/HALT.
// Instruction and data memories via req/ack handshakes.
module m_proc_mc #(
  parameter int          IMEM_AW  = 11,
  parameter int          DMEM_AW  = 11,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          LED_REG  = 30
) (
  input  logic               w_clk,
  input  logic               w_rst_n,
  output logic               w_imem_req,
  output logic [IMEM_AW-1:0] w_imem_addr,
  input  logic               w_imem_ack,
  input  logic [31:0]        w_imem_rdata,
  output logic               w_dmem_req,
  output logic               w_dmem_we,
  output logic [DMEM_AW-1:0] w_dmem_addr,
  output logic [31:0]        w_dmem_wdata,
  input  logic               w_dmem_ack,
  input  logic [31:0]        w_dmem_rdata,
  output logic [31:0]        r_led,
  output logic               w_halt
);
  import mc_pkg::*;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, rs_q, rt_q, imm_q;
  logic [31:0] pc4_q, tpc_q, rslt_q, ld_q;
  logic        take_q;

  alu_op_t     alu_op;
  logic        use_imm, wr_en, is_lw, is_sw;
  logic        is_beq, is_bne, is_j, is_halt, is_mem;
  logic [4:0]  dst;
  logic [31:0] imm_x, alu_b, alu_y, npc, wb_data;
  logic [31:0] rf_rd1, rf_rd2;
  logic        rf_we;

  m_regfile_rn u_rf (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_ra1   (ir_q[25:21]),
    .w_ra2   (ir_q[20:16]),
    .w_we    (rf_we),
    .w_wa    (dst),
    .w_wd    (wb_data),
    .w_rd1   (rf_rd1),
    .w_rd2   (rf_rd2)
  );

  // instruction decode from the latched IR
  always_comb begin
    alu_op  = ALU_NOP;
    use_imm = 1'b0;
    wr_en   = 1'b0;
    dst     = ir_q[15:11];
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_halt = 1'b0;
    unique case (1'b1)
      ir_q[31:26] == OP_RTYPE: begin
        wr_en = 1'b1;
        case (ir_q[5:0])
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLLV: alu_op = ALU_SLL;
          FN_SRLV: alu_op = ALU_SRL;
          default: wr_en  = 1'b0;
        endcase
      end
      ir_q[31:26] == OP_ADDI: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        wr_en   = 1'b1;
        dst     = ir_q[20:16];
      end
      ir_q[31:26] == OP_LW: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        wr_en   = 1'b1;
        dst     = ir_q[20:16];
        is_lw   = 1'b1;
      end
      ir_q[31:26] == OP_SW: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        is_sw   = 1'b1;
      end
      ir_q[31:26] == OP_BEQ:  is_beq  = 1'b1;
      ir_q[31:26] == OP_BNE:  is_bne  = 1'b1;
      ir_q[31:26] == OP_J:    is_j    = 1'b1;
      ir_q[31:26] == OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign is_mem = is_lw | is_sw;
  assign imm_x  = {{16{ir_q[15]}}, ir_q[15:0]};

  // ALU on the operands latched in ID
  always_comb begin
    alu_y = '0;
    alu_b = use_imm ? imm_q : rt_q;
    case (alu_op)
      ALU_ADD: alu_y = rs_q + alu_b;
      ALU_SUB: alu_y = rs_q - alu_b;
      ALU_AND: alu_y = rs_q & alu_b;
      ALU_OR:  alu_y = rs_q | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_q) < $signed(alu_b)};
      ALU_SLL: alu_y = rt_q << rs_q[4:0];
      ALU_SRL: alu_y = rt_q >> rs_q[4:0];
      default: alu_y = '0;
    endcase
  end

  // next-pc selection and write-back data
  always_comb begin
    npc = pc4_q;
    if (take_q) npc = tpc_q;
    else if (is_j) npc = {pc4_q[31:28], ir_q[25:0], 2'b00};
    wb_data = is_lw ? ld_q : rslt_q;
    rf_we   = (state_q == S_WB) && wr_en;
  end

  // state register
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  // next state and handshake outputs; reqs gated by reset
  always_comb begin
    state_d      = state_q;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_halt       = 1'b0;
    case (state_q)
      S_IF: begin
        w_imem_req = w_rst_n;
        if (w_imem_ack) state_d = S_ID;
      end
      S_ID: state_d = S_EX;
      S_EX: state_d = S_MEM;
      S_MEM: begin
        w_dmem_req = w_rst_n && is_mem;
        if (!is_mem || w_dmem_ack) state_d = S_WB;
      end
      S_WB:   state_d = is_halt ? S_HALT : S_IF;
      S_HALT: w_halt = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  assign w_imem_addr  = pc_q[IMEM_AW+1:2];
  assign w_dmem_addr  = rslt_q[DMEM_AW+1:2];
  assign w_dmem_we    = is_sw;
  assign w_dmem_wdata = rt_q;

  // datapath registers advanced per state
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      pc_q   <= RESET_PC;
      ir_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      imm_q  <= '0;
      pc4_q  <= '0;
      tpc_q  <= '0;
      rslt_q <= '0;
      ld_q   <= '0;
      take_q <= 1'b0;
      r_led  <= '0;
    end else begin
      case (state_q)
        S_IF: if (w_imem_ack) ir_q <= w_imem_rdata;
        S_ID: begin
          rs_q  <= rf_rd1;
          rt_q  <= rf_rd2;
          imm_q <= imm_x;
          pc4_q <= pc_q + 32'd4;
          tpc_q <= pc_q + 32'd4 + {imm_x[29:0], 2'b00};
        end
        S_EX: begin
          rslt_q <= alu_y;
          take_q <= (is_beq && (rs_q == rt_q)) ||
                    (is_bne && (rs_q != rt_q));
        end
        S_MEM: if (is_lw && w_dmem_ack) ld_q <= w_dmem_rdata;
        S_WB: begin
          if (!is_halt) pc_q <= npc;
          if (rf_we && (dst != 5'd0) && (dst == 5'(LED_REG)))
            r_led <= wb_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_proc_mc.sv
// Scoreboard bench for m_proc_mc: ISA-level model fills
// expected fetch/data queues, a monitor pops and compares.
module tb_m_proc_mc;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        w_imem_req;
  logic [10:0] w_imem_addr;
  logic        w_imem_ack = 1'b0;
  logic [31:0] w_imem_rdata = '0;
  logic        w_dmem_req;
  logic        w_dmem_we;
  logic [10:0] w_dmem_addr;
  logic [31:0] w_dmem_wdata;
  logic        w_dmem_ack = 1'b0;
  logic [31:0] w_dmem_rdata = '0;
  logic [31:0] r_led;
  logic        w_halt;

  m_proc_mc dut (
    .w_clk        (w_clk),
    .w_rst_n      (w_rst_n),
    .w_imem_req   (w_imem_req),
    .w_imem_addr  (w_imem_addr),
    .w_imem_ack   (w_imem_ack),
    .w_imem_rdata (w_imem_rdata),
    .w_dmem_req   (w_dmem_req),
    .w_dmem_we    (w_dmem_we),
    .w_dmem_addr  (w_dmem_addr),
    .w_dmem_wdata (w_dmem_wdata),
    .w_dmem_ack   (w_dmem_ack),
    .w_dmem_rdata (w_dmem_rdata),
    .r_led        (r_led),
    .w_halt       (w_halt)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
  } ev_t;

  ev_t         fq[$];
  ev_t         dq[$];
  logic [31:0] imem [2048];
  logic [31:0] dmem [2048];
  logic [31:0] mdm  [2048];
  logic [31:0] m_led, m_hpc;
  int          n_chk = 0;
  int          n_fail = 0;
  int          iwm = 0;
  int          dwm = 0;
  bit          noise = 1'b0;
  bit          force_ack = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic miss(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  function automatic logic [31:0] enc_r(int fn, int rd, int rs, int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rt, int rs, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic int pick(int m);
    return (m < 0) ? int'($urandom_range(0, 3)) : m;
  endfunction

  // ISA-level reference: executes the program, queues expected events
  task automatic run_model();
    logic [31:0] r [32];
    logic [31:0] pc, npc, ins, a, b, imm, val, led, wa;
    logic [4:0]  dst;
    bit          wr, halted;
    for (int i = 0; i < 32; i++) r[i] = '0;
    for (int i = 0; i < 2048; i++) mdm[i] = dmem[i];
    fq.delete();
    dq.delete();
    pc = 32'h0;
    led = '0;
    halted = 1'b0;
    m_hpc = '0;
    for (int s = 0; s < 1000 && !halted; s++) begin
      ins = imem[pc[12:2]];
      fq.push_back('{a: 32'(pc[12:2]), d: led, we: 1'b0});
      a   = r[ins[25:21]];
      b   = r[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      npc = pc + 4;
      wr  = 1'b0;
      dst = ins[20:16];
      val = '0;
      case (ins[31:26])
        6'h00: begin
          dst = ins[15:11];
          wr  = 1'b1;
          case (ins[5:0])
            6'h20: val = a + b;
            6'h22: val = a - b;
            6'h24: val = a & b;
            6'h25: val = a | b;
            6'h2a: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h04: val = b << a[4:0];
            6'h06: val = b >> a[4:0];
            default: wr = 1'b0;
          endcase
        end
        6'h08: begin wr = 1'b1; val = a + imm; end
        6'h23: begin
          wa = a + imm;
          dq.push_back('{a: 32'(wa[12:2]), d: '0, we: 1'b0});
          val = mdm[wa[12:2]];
          wr = 1'b1;
        end
        6'h2b: begin
          wa = a + imm;
          dq.push_back('{a: 32'(wa[12:2]), d: b, we: 1'b1});
          mdm[wa[12:2]] = b;
        end
        6'h04: if (a == b) npc = pc + 4 + (imm << 2);
        6'h05: if (a != b) npc = pc + 4 + (imm << 2);
        6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
        6'h3f: begin halted = 1'b1; m_hpc = pc; end
        default: ;
      endcase
      if (wr && dst != 5'd0) begin
        r[dst] = val;
        if (dst == 5'd30) led = val;
      end
      if (!halted) pc = npc;
    end
    m_led = led;
  endtask

  // memory responders with programmable wait states and ack noise
  int icnt = 0, itgt = 0, dcnt = 0, dtgt = 0;
  always @(negedge w_clk) begin
    if (!w_rst_n) begin
      w_imem_ack = force_ack;
      w_dmem_ack = force_ack;
      icnt = 0;
      dcnt = 0;
      itgt = pick(iwm);
      dtgt = pick(dwm);
    end else begin
      if (w_imem_req) begin
        if (icnt >= itgt) begin
          w_imem_ack = 1'b1;
          w_imem_rdata = imem[w_imem_addr];
          icnt = 0;
          itgt = pick(iwm);
        end else begin
          w_imem_ack = 1'b0;
          w_imem_rdata = $urandom;
          icnt++;
        end
      end else begin
        w_imem_ack = noise && ($urandom_range(0, 3) == 0);
        w_imem_rdata = $urandom;
      end
      if (w_dmem_req) begin
        if (dcnt >= dtgt) begin
          w_dmem_ack = 1'b1;
          if (w_dmem_we) dmem[w_dmem_addr] = w_dmem_wdata;
          else w_dmem_rdata = dmem[w_dmem_addr];
          dcnt = 0;
          dtgt = pick(dwm);
        end else begin
          w_dmem_ack = 1'b0;
          w_dmem_rdata = $urandom;
          dcnt++;
        end
      end else begin
        w_dmem_ack = noise && ($urandom_range(0, 3) == 0);
        w_dmem_rdata = $urandom;
      end
    end
  end

  // monitor: handshakes, request stability, per-instruction latency
  int          cyc = 0, last_hs = 0, iw = 0, dw = 0;
  bit          have_prev = 1'b0, ipend = 1'b0, dpend = 1'b0;
  logic [31:0] ia_p, da_p, dd_p;
  logic        dwe_p;
  always @(negedge w_clk) begin
    ev_t e;
    #1;
    if (!w_rst_n) begin
      have_prev = 1'b0;
      ipend = 1'b0;
      dpend = 1'b0;
      iw = 0;
      dw = 0;
    end else begin
      cyc++;
      if (ipend) begin
        chk("imem_req_held", 32'(w_imem_req), 32'd1);
        chk("imem_addr_stable", 32'(w_imem_addr), ia_p);
      end
      if (dpend) begin
        chk("dmem_req_held", 32'(w_dmem_req), 32'd1);
        chk("dmem_addr_stable", 32'(w_dmem_addr), da_p);
        chk("dmem_we_stable", 32'(w_dmem_we), 32'(dwe_p));
        chk("dmem_wdata_stable", w_dmem_wdata, dd_p);
      end
      if (w_imem_req && w_imem_ack) begin
        if (fq.size() == 0) miss("fetch_extra");
        else begin
          e = fq.pop_front();
          chk("fetch_addr", 32'(w_imem_addr), e.a);
          chk("led_at_fetch", r_led, e.d);
          if (have_prev)
            chk("instr_latency", 32'(cyc - last_hs), 32'(5 + iw + dw));
          have_prev = 1'b1;
          last_hs = cyc;
          iw = 0;
          dw = 0;
        end
      end else if (w_imem_req) iw++;
      if (w_dmem_req && w_dmem_ack) begin
        if (dq.size() == 0) miss("dmem_extra");
        else begin
          e = dq.pop_front();
          chk("dmem_we", 32'(w_dmem_we), 32'(e.we));
          chk("dmem_addr", 32'(w_dmem_addr), e.a);
          if (e.we) chk("dmem_wdata", w_dmem_wdata, e.d);
        end
      end else if (w_dmem_req) dw++;
      ipend = w_imem_req && !w_imem_ack;
      dpend = w_dmem_req && !w_dmem_ack;
      ia_p  = 32'(w_imem_addr);
      da_p  = 32'(w_dmem_addr);
      dd_p  = w_dmem_wdata;
      dwe_p = w_dmem_we;
    end
  end

  task automatic load_clear();
    for (int i = 0; i < 2048; i++) begin
      imem[i] = '0;
      dmem[i] = $urandom;
    end
  endtask

  // called with reset asserted: build expectations, then release
  task automatic start();
    run_model();
    repeat (2) @(negedge w_clk);
    #3 w_rst_n = 1'b1;
  endtask

  task automatic finish_phase(string nm);
    int n = 0;
    while (!w_halt && n < 3000) begin
      @(negedge w_clk);
      n++;
    end
    if (!w_halt) miss({nm, "_halt_timeout"});
    repeat (4) @(negedge w_clk);
    #2;
    chk({nm, "_halt"}, 32'(w_halt), 32'd1);
    chk({nm, "_led"}, r_led, m_led);
    chk({nm, "_halt_pc"}, 32'(w_imem_addr), 32'(m_hpc[12:2]));
    chk({nm, "_no_fetch"}, 32'(w_imem_req), 32'd0);
    chk({nm, "_fq_left"}, 32'(fq.size()), 32'd0);
    chk({nm, "_dq_left"}, 32'(dq.size()), 32'd0);
    w_rst_n = 1'b0;
  endtask

  function automatic int rreg();
    int r = $urandom_range(0, 8);
    return (r == 8) ? 30 : r;
  endfunction

  initial begin
    int fns[7] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2a, 32'h04, 32'h06};
    int n;
    w_rst_n = 1'b0;
    #1;
    chk("rst_imem_req", 32'(w_imem_req), 32'd0);
    chk("rst_dmem_req", 32'(w_dmem_req), 32'd0);
    chk("rst_led", r_led, 32'd0);
    chk("rst_halt", 32'(w_halt), 32'd0);
    chk("rst_pc", 32'(w_imem_addr), 32'd0);

    load_clear();
    imem[0] = enc_i(8, 1, 0, 5);
    imem[1] = enc_i(8, 2, 0, 7);
    imem[2] = enc_r(32'h20, 30, 1, 2);
    imem[3] = enc_i(32'h3f, 0, 0, 0);
    start();
    finish_phase("basic");

    iwm = 3;
    noise = 1'b1;
    start();
    finish_phase("imem_wait3");

    load_clear();
    imem[0] = enc_i(8, 3, 0, -1);
    imem[1] = enc_i(32'h2b, 3, 0, 8);
    imem[2] = enc_i(32'h23, 30, 0, 8);
    imem[3] = enc_i(32'h3f, 0, 0, 0);
    iwm = 0;
    dwm = 2;
    start();
    finish_phase("store_load");
    chk("stored_word", dmem[2], 32'hFFFF_FFFF);

    load_clear();
    imem[0] = enc_i(8, 4, 0, 3);
    imem[1] = enc_i(8, 1, 1, 1);
    imem[2] = enc_i(5, 4, 1, -2);
    imem[3] = enc_r(32'h20, 30, 1, 0);
    imem[4] = enc_i(8, 3, 0, -1);
    imem[5] = enc_r(32'h2a, 30, 0, 3);
    imem[6] = enc_i(32'h3f, 0, 0, 0);
    iwm = -1;
    dwm = -1;
    start();
    finish_phase("loop_slt");

    load_clear();
    imem[0] = enc_i(8, 1, 0, 4);
    imem[1] = enc_i(8, 30, 0, 7);
    imem[2] = 32'hF800_0000;
    imem[3] = enc_r(32'h20, 0, 1, 1);
    imem[4] = enc_r(32'h3f, 30, 1, 1);
    imem[5] = enc_r(32'h20, 30, 0, 1);
    imem[6] = enc_i(32'h3f, 0, 0, 0);
    start();
    finish_phase("undefined");

    load_clear();
    imem[0] = enc_i(8, 30, 0, 9);
    imem[1] = enc_i(8, 3, 0, 5);
    imem[2] = enc_i(32'h2b, 3, 0, 4);
    imem[3] = enc_i(32'h3f, 0, 0, 0);
    iwm = 0;
    dwm = 40;
    noise = 1'b0;
    start();
    n = 0;
    while (!w_dmem_req && n < 200) begin
      @(negedge w_clk);
      n++;
    end
    if (!w_dmem_req) miss("reset_wait_dmem_req");
    repeat (3) @(negedge w_clk);
    #2 w_rst_n = 1'b0;
    #1;
    chk("midrst_dmem_req", 32'(w_dmem_req), 32'd0);
    chk("midrst_imem_req", 32'(w_imem_req), 32'd0);
    chk("midrst_led", r_led, 32'd0);
    chk("midrst_halt", 32'(w_halt), 32'd0);
    chk("midrst_pc", 32'(w_imem_addr), 32'd0);
    force_ack = 1'b1;
    repeat (2) @(negedge w_clk);
    #1;
    chk("stale_ack_dmem_req", 32'(w_dmem_req), 32'd0);
    force_ack = 1'b0;
    @(negedge w_clk);
    dwm = 1;
    start();
    finish_phase("reset_restart");

    for (int p = 0; p < 6; p++) begin
      load_clear();
      for (int k = 0; k < 24; k++) begin
        int s = $urandom_range(0, 11);
        case (s)
          0, 1, 2, 3, 4, 5, 6:
            imem[k] = enc_r(fns[s], rreg(), rreg(), rreg());
          7: imem[k] = enc_i(8, rreg(), rreg(), $urandom_range(0, 65535));
          8: imem[k] = enc_i(32'h23, rreg(), 0, 4 * $urandom_range(0, 15));
          9: imem[k] = enc_i(32'h2b, rreg(), 0, 4 * $urandom_range(0, 15));
          10: begin
            case ($urandom_range(0, 2))
              0: imem[k] = enc_i(4, 0, 0, 1);
              1: imem[k] = enc_i(5, rreg(), rreg(), 1);
              default: imem[k] = {6'h02, 26'(k + 2)};
            endcase
          end
          default: imem[k] = {6'h3e, 26'($urandom)};
        endcase
      end
      imem[24] = enc_i(32'h3f, 0, 0, 0);
      imem[25] = enc_i(32'h3f, 0, 0, 0);
      iwm = -1;
      dwm = -1;
      noise = 1'b1;
      start();
      finish_phase("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
